// File: rtl/aibcr3pnr_dll_lock_mon.sv
// DLL lock monitor: watches the DLL phase-detector up/dn dither after reset release, declares
// lock, detects loss of lock or acquisition failure, and requests a DLL re-reset when enabled.
module aibcr3pnr_dll_lock_mon #(
  parameter int SETTLE_W = 10,
  parameter int CNT_W    = 6,
  parameter int WIN_W    = 8,
  parameter int MAX_WIN  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                dll_reset_n,
  input  logic                pd_up,
  input  logic                pd_dn,
  input  logic [SETTLE_W-1:0] rb_settle_cyc,
  input  logic [CNT_W-1:0]    rb_lock_thr,
  input  logic [CNT_W-1:0]    rb_unlock_run,
  input  logic                rb_relock_en,
  output logic                dll_lock,
  output logic                lock_fail,
  output logic                reinit_req,
  output logic [2:0]          mon_state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_ACQUIRE = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_REQ     = 3'd4,
    ST_FAIL    = 3'd5
  } state_t;

  localparam logic [1:0] DIR_NONE = 2'd0;
  localparam logic [1:0] DIR_UP   = 2'd1;
  localparam logic [1:0] DIR_DN   = 2'd2;

  localparam int FAIL_W = (MAX_WIN > 1) ? $clog2(MAX_WIN) : 1;
  localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_WIN - 1);

  state_t              state;
  state_t              state_nx;
  logic [SETTLE_W-1:0] scnt;
  logic [WIN_W-1:0]    win_cnt;
  logic [CNT_W-1:0]    rev_cnt;
  logic [CNT_W-1:0]    run_cnt;
  logic [FAIL_W-1:0]   fail_cnt;
  logic [1:0]          last_dir;

  logic                ev_up;
  logic                ev_dn;
  logic                ev_inv;
  logic                reversal;
  logic                same_dir;
  logic [1:0]          dir_next;
  logic [CNT_W-1:0]    rev_next;
  logic [CNT_W-1:0]    run_next;
  logic                settle_done;
  logic                lock_hit;
  logic                win_end;
  logic                fail_last;
  logic                unlock_hit;

  // Per-cycle direction event; a simultaneous up and dn is treated as invalid, not a direction.
  assign ev_up    = pd_up & ~pd_dn;
  assign ev_dn    = pd_dn & ~pd_up;
  assign ev_inv   = pd_up & pd_dn;
  assign reversal = (ev_up && (last_dir == DIR_DN)) || (ev_dn && (last_dir == DIR_UP));
  assign same_dir = (ev_up && (last_dir == DIR_UP)) || (ev_dn && (last_dir == DIR_DN));
  assign dir_next = ev_up ? DIR_UP : (ev_dn ? DIR_DN : last_dir);

  assign rev_next = (reversal && (rev_cnt != {CNT_W{1'b1}})) ? rev_cnt + CNT_W'(1) : rev_cnt;

  always_comb begin
    run_next = run_cnt;
    if (ev_inv) begin
      run_next = '0;
    end else if (same_dir) begin
      if (run_cnt != {CNT_W{1'b1}}) run_next = run_cnt + CNT_W'(1);
    end else if (ev_up || ev_dn) begin
      run_next = CNT_W'(1);
    end
  end

  assign settle_done = (scnt == rb_settle_cyc);
  assign lock_hit    = (rev_next >= rb_lock_thr);
  assign win_end     = (win_cnt == {WIN_W{1'b1}});
  assign fail_last   = (fail_cnt == FAIL_LAST);
  assign unlock_hit  = (rb_unlock_run != '0) && (run_next == rb_unlock_run);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // dll_reset_n low overrides every state; it is the only way out of REQ and FAIL.
  always_comb begin
    state_nx = state;
    if (!dll_reset_n) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    state_nx = ST_SETTLE;
        ST_SETTLE:  if (settle_done) state_nx = ST_ACQUIRE;
        ST_ACQUIRE: begin
          if (lock_hit)                state_nx = ST_LOCKED;
          else if (win_end && fail_last) state_nx = ST_FAIL;
        end
        ST_LOCKED:  if (unlock_hit) state_nx = rb_relock_en ? ST_REQ : ST_ACQUIRE;
        ST_REQ:     state_nx = ST_REQ;
        ST_FAIL:    state_nx = ST_FAIL;
        default:    state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !dll_reset_n) begin
      scnt     <= '0;
      win_cnt  <= '0;
      rev_cnt  <= '0;
      run_cnt  <= '0;
      fail_cnt <= '0;
      last_dir <= DIR_NONE;
    end else begin
      case (state)
        ST_IDLE: scnt <= '0;
        ST_SETTLE: begin
          scnt <= scnt + SETTLE_W'(1);
          if (settle_done) begin
            win_cnt  <= '0;
            rev_cnt  <= '0;
            fail_cnt <= '0;
            last_dir <= DIR_NONE;
          end
        end
        ST_ACQUIRE: begin
          if (lock_hit) begin
            run_cnt  <= '0;
            last_dir <= dir_next;
          end else if (win_end) begin
            // Failed window: start the next one from scratch.
            win_cnt  <= '0;
            rev_cnt  <= '0;
            last_dir <= DIR_NONE;
            if (!fail_last) fail_cnt <= fail_cnt + FAIL_W'(1);
          end else begin
            win_cnt  <= win_cnt + WIN_W'(1);
            rev_cnt  <= rev_next;
            last_dir <= dir_next;
          end
        end
        ST_LOCKED: begin
          run_cnt  <= run_next;
          last_dir <= dir_next;
          if (unlock_hit && !rb_relock_en) begin
            win_cnt  <= '0;
            rev_cnt  <= '0;
            fail_cnt <= '0;
            last_dir <= DIR_NONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    dll_lock   = (state == ST_LOCKED);
    lock_fail  = (state == ST_FAIL);
    reinit_req = (state == ST_REQ) || ((state == ST_FAIL) && rb_relock_en);
    mon_state  = state;
  end

endmodule

// File: tb/tb_aibcr3pnr_dll_lock_mon.sv
// Bench for the DLL lock monitor: directed vector table, hand-written corner sequences and
// randomized traffic, all checked cycle by cycle against a behavioural model.
module tb_aibcr3pnr_dll_lock_mon;

  localparam int SETTLE_W = 10;
  localparam int CNT_W    = 6;
  localparam int WIN_W    = 8;
  localparam int MAX_WIN  = 4;
  localparam int W        = 6;

  localparam int S_IDLE = 0, S_SETTLE = 1, S_ACQ = 2, S_LOCKED = 3, S_REQ = 4, S_FAIL = 5;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                dll_reset_n = 1'b0;
  logic                pd_up = 1'b0;
  logic                pd_dn = 1'b0;
  logic [SETTLE_W-1:0] rb_settle_cyc = '0;
  logic [CNT_W-1:0]    rb_lock_thr = '0;
  logic [CNT_W-1:0]    rb_unlock_run = '0;
  logic                rb_relock_en = 1'b0;
  logic                dll_lock;
  logic                lock_fail;
  logic                reinit_req;
  logic [2:0]          mon_state;

  aibcr3pnr_dll_lock_mon #(
    .SETTLE_W(SETTLE_W), .CNT_W(CNT_W), .WIN_W(WIN_W), .MAX_WIN(MAX_WIN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .dll_reset_n(dll_reset_n), .pd_up(pd_up), .pd_dn(pd_dn),
    .rb_settle_cyc(rb_settle_cyc), .rb_lock_thr(rb_lock_thr), .rb_unlock_run(rb_unlock_run),
    .rb_relock_en(rb_relock_en), .dll_lock(dll_lock), .lock_fail(lock_fail),
    .reinit_req(reinit_req), .mon_state(mon_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // behavioural model: whole-number counters, direction as 0 none / 1 up / 2 dn
  int m_state = S_IDLE, m_scnt = 0, m_win = 0, m_rev = 0, m_fail = 0, m_run = 0, m_last = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [W-1:0] model_outputs();
    logic lk, fl, rq;
    lk = (m_state == S_LOCKED);
    fl = (m_state == S_FAIL);
    rq = (m_state == S_REQ) || ((m_state == S_FAIL) && rb_relock_en);
    return {lk, fl, rq, 3'(m_state)};
  endfunction

  function automatic void model_step(bit r, bit d, bit u, bit n);
    int dir, nrev, sat;
    bit rev;
    sat  = (1 << CNT_W) - 1;
    dir  = (u && !n) ? 1 : ((n && !u) ? 2 : ((u && n) ? 3 : 0));
    rev  = (dir == 1 && m_last == 2) || (dir == 2 && m_last == 1);
    if (!r || !d) begin
      m_state = S_IDLE; m_scnt = 0; m_win = 0; m_rev = 0; m_fail = 0; m_run = 0; m_last = 0;
      return;
    end
    case (m_state)
      S_IDLE: begin m_state = S_SETTLE; m_scnt = 0; end
      S_SETTLE: begin
        if (m_scnt == int'(rb_settle_cyc)) begin
          m_state = S_ACQ; m_win = 0; m_rev = 0; m_last = 0; m_fail = 0;
        end else m_scnt++;
      end
      S_ACQ: begin
        nrev = (m_rev + int'(rev) > sat) ? sat : m_rev + int'(rev);
        if (dir == 1 || dir == 2) m_last = dir;
        if (nrev >= int'(rb_lock_thr)) begin
          m_state = S_LOCKED; m_run = 0;
        end else if (m_win == (1 << WIN_W) - 1) begin
          if (m_fail == MAX_WIN - 1) m_state = S_FAIL;
          else begin m_fail++; m_win = 0; m_rev = 0; m_last = 0; end
        end else begin
          m_win++; m_rev = nrev;
        end
      end
      S_LOCKED: begin
        if (dir == 3) m_run = 0;
        else if (dir != 0) begin
          if (dir == m_last) m_run = (m_run + 1 > sat) ? sat : m_run + 1;
          else m_run = 1;
          m_last = dir;
        end
        if (rb_unlock_run != 0 && m_run == int'(rb_unlock_run)) begin
          if (rb_relock_en) m_state = S_REQ;
          else begin m_state = S_ACQ; m_win = 0; m_rev = 0; m_last = 0; m_fail = 0; end
        end
      end
      default: ;
    endcase
  endfunction

  // driver: apply one cycle of inputs, predict, then compare after the edge
  task automatic step(input logic r, input logic d, input logic u, input logic n);
    logic [W-1:0] got, exp;
    rst_n = r; dll_reset_n = d; pd_up = u; pd_dn = n;
    model_step(r, d, u, n);
    exp_q.push_back(model_outputs());
    @(posedge clk); #1;
    got = {dll_lock, lock_fail, reinit_req, mon_state};
    exp = exp_q.pop_front();
    check("model", 32'(got), 32'(exp));
  endtask

  task automatic go_locked(input int thr);
    rb_settle_cyc = '0; rb_lock_thr = CNT_W'(thr);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    if (thr == 0) step(1, 1, 0, 0);
    else for (int i = 0; i <= thr; i++) step(1, 1, (i % 2) == 0, (i % 2) == 1);
    check("go_locked_state", 32'(mon_state), S_LOCKED);
  endtask

  typedef struct {
    logic r, d, u, n;
    logic [2:0] st;
    logic lk, fl, rq;
  } vec_t;

  vec_t tbl[28];

  initial begin
    int n;
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[19] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0};
    tbl[20] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[21] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0};
    tbl[22] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0};
    tbl[23] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0};
    tbl[24] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0};
    tbl[25] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0};
    tbl[26] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0};
    tbl[27] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};

    // settle 3, lock at 4 reversals, unlock after a run of 5, relock through re-reset
    rb_settle_cyc = SETTLE_W'(3); rb_lock_thr = CNT_W'(4);
    rb_unlock_run = CNT_W'(5);    rb_relock_en = 1'b1;
    for (int i = 0; i < 28; i++) begin
      step(tbl[i].r, tbl[i].d, tbl[i].u, tbl[i].n);
      check($sformatf("tbl[%0d]", i), 32'({dll_lock, lock_fail, reinit_req, mon_state}),
            32'({tbl[i].lk, tbl[i].fl, tbl[i].rq, tbl[i].st}));
    end

    // acquisition failure: constant up never reverses
    rb_settle_cyc = '0; rb_lock_thr = CNT_W'(4); rb_relock_en = 1'b1;
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    check("fail_acq_entry", 32'(mon_state), S_ACQ);
    n = 0;
    do begin
      step(1, 1, 1, 0);
      n++;
    end while (mon_state == 3'(S_ACQ) && n < 1100);
    check("fail_cycles", 32'(n), 32'(1024));
    check("fail_outs", 32'({lock_fail, reinit_req}), 32'(2'b11));
    rb_relock_en = 1'b0;
    #1;
    check("fail_req_live", 32'(reinit_req), 32'(0));
    rb_relock_en = 1'b1;
    step(1, 1, 0, 0);
    check("fail_hold", 32'({lock_fail, reinit_req}), 32'(2'b11));
    step(1, 0, 0, 0);
    check("fail_release", 32'({lock_fail, reinit_req, mon_state}), 32'(5'b00000));

    // unlock without re-reset: run survives holds
    rb_unlock_run = CNT_W'(5); rb_relock_en = 1'b1;
    go_locked(4);
    rb_relock_en = 1'b0;
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
    check("t4_pre", 32'({dll_lock, mon_state}), 32'({1'b1, 3'd3}));
    step(1, 1, 1, 0);
    check("t4_unlock", 32'({dll_lock, reinit_req, mon_state}), 32'({1'b0, 1'b0, 3'd2}));

    // unlock detection disabled
    rb_unlock_run = '0;
    go_locked(4);
    for (int i = 0; i < 10000; i++) step(1, 1, 1, 0);
    check("t5_still_locked", 32'(dll_lock), 32'(1));

    // zero threshold locks after one acquire cycle
    go_locked(0);
    check("thr0_lock", 32'(dll_lock), 32'(1));

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        rb_settle_cyc = SETTLE_W'($urandom_range(0, 7));
        rb_lock_thr   = CNT_W'($urandom_range(0, 10));
        rb_unlock_run = CNT_W'($urandom_range(0, 8));
        rb_relock_en  = 1'($urandom_range(0, 1));
      end
      step($urandom_range(0, 499) != 0, $urandom_range(0, 199) != 0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
